sha256_core_iter: RTL and testbench
===================================

Name: sha256_core_iter

Overview:
- Parametrised iterative SHA-256/SHA-224 compression core, the successor to the single-block 3-cycle hash FSM.
- Accepts pre-padded 512-bit blocks over a valid/ready handshake and chains multi-block messages through internal H registers.
- Runs ROUNDS_PER_CLK unrolled rounds per clock, so throughput versus area is set at build time.
- Sits between the padding/front-end logic and the digest consumer.

Parameters:
- ROUNDS_PER_CLK, 1, rounds per clock. Legal values: 1, 2, 4, 8, 16. Any other value is an elaboration error.
- SUPPORT_224, 1, enables SHA-224 mode. When 0, mode_224 is ignored and the core runs SHA-256 only.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- blk_valid  in  1  block offered
- blk_ready  out  1  core can accept a block
- blk_data  in  512  padded block. Word 0 is blk_data[511:480]; words are big-endian.
- blk_first  in  1  first block of a message; reload IV
- blk_last  in  1  final block of a message; produce digest
- mode_224  in  1  SHA-224 select. Sampled only on an accepted first block.
- digest  out  256  result. In SHA-224 mode: H0..H6 in [255:32], [31:0]=0.
- digest_valid  out  1  one-cycle pulse when digest updates
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset: state=IDLE, blk_ready=1, busy=0, digest_valid=0, digest=0, chain_active=0, round counter=0, H=IV256.
- Reset applied mid-operation aborts the block; there is no partial digest.
- FSM states: IDLE, ROUND, FINAL.
- IDLE
  - blk_ready=1.
  - Accept when blk_valid && blk_ready, at cycle T.
  - On accept: latch the 16 words into the schedule window, latch flags, move to ROUND.
  - Working vars a..h are loaded from:
    - IV when blk_first=1 or chain_active=0. The IV is IV224 if mode_224=1 and SUPPORT_224=1, else IV256. The chosen IV is also written to H.
    - current H otherwise. mode is retained from the chain's first block.
- ROUND
  - Occupies cycles T+1 .. T+64/R, where R=ROUNDS_PER_CLK.
  - Each cycle applies R chained rounds.
  - The message schedule is a rolling 16-word shift window. Each cycle it shifts by R, appending W[t+16] = σ1(W[t+14]) + W[t+9] + σ0(W[t+1]) + W[t].
  - The K index is the round counter, which advances by R per cycle.
  - All arithmetic is mod 2^32.
  - Leave ROUND when the counter reaches 64.
- FINAL
  - One cycle, T+64/R+1.
  - H[i] <= H[i] + working var[i].
  - If blk_last: digest <= new H (SHA-224 format if chain is 224); digest_valid=1 in cycle T+64/R+2; chain_active <= 0.
  - Else: chain_active <= 1, with no digest_valid.
  - Return to IDLE.
- Latency: accept to digest_valid is 64/R+2 cycles (R=1: 66; R=4: 18; R=16: 6).
- Back-to-back: blk_ready rises in the same cycle digest_valid pulses. The next block can be accepted that cycle.
- digest holds its value until the next digest_valid; it is not cleared on a new message.
- blk_first=1 while chain_active=1 silently abandons the previous chain.
- blk_first=1 with blk_last=1 is a single-block message.
- blk_valid while busy is ignored. The input is not latched, and the producer must hold it.
- blk_data, blk_first, blk_last and mode_224 are don't-care unless accepted.

Decomposition:
- Package sha256_pkg holds:
  - K[0:63] constant array
  - IV256 and IV224 constants
  - functions Σ0, Σ1, σ0, σ1, ch, maj
  - state_t enum {IDLE, ROUND, FINAL}
  - typedef word_t = logic [31:0]
- Sub-module sha256_round: combinational single round, taking a..h, K, W and producing next a..h. It is instantiated R times in a generate chain inside sha256_core_iter.

Test Plan:
- "abc" SHA-256, single block 61626380 0…0 00000018, first=last=1 → digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad. digest_valid arrives exactly 64/R+2 cycles after accept. Run for R=1, 4 and 16.
- Empty string, block 80000000 0…0, → e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (first then last, back-to-back) → 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1. There is no digest_valid after block 1.
- SHA-224 "abc" with mode_224=1 → digest 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7 00000000. Then an immediate SHA-256 "abc" gives the 256 result, which checks mode re-sampling.
- Assert rst during ROUND of "abc" → next cycle IDLE, blk_ready=1, digest=0, with no digest_valid. A re-issued "abc" gives the correct digest.
- Hold blk_valid high while busy with different data → that data is ignored. An abandoned chain (first-block, then a new first=last "abc") still gives ba7816bf….

Source files
------------

// File: rtl/sha256_pkg.sv
// sha256_pkg: shared SHA-2 (256/224) constants, types and bit functions.
//   word_t        32-bit datapath word
//   state_t       control FSM states of sha256_core_iter
//   K             64 round constants
//   IV256, IV224  initial hash values, H0 in [255:224]
//   big_sigma0/1, small_sigma0/1, ch, maj: FIPS 180-4 logical functions
package sha256_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2
    } state_t;

    localparam word_t K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] IV256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [255:0] IV224 = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    function automatic word_t k_at(input logic [5:0] idx);
        return K[idx];
    endfunction

    function automatic word_t big_sigma0(input word_t x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic word_t big_sigma1(input word_t x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic word_t small_sigma0(input word_t x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic word_t small_sigma1(input word_t x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    function automatic word_t ch(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic word_t maj(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// sha256_round: one combinational SHA-256 compression round.
//   st_i  working variables a..h packed, a in [255:224]
//   k_i   round constant K[t]
//   w_i   schedule word W[t]
//   st_o  working variables after the round
module sha256_round
    import sha256_pkg::*;
(
    input  logic [255:0] st_i,
    input  word_t        k_i,
    input  word_t        w_i,
    output logic [255:0] st_o
);

    word_t a, b, c, d, e, f, g, h;
    word_t t1, t2;

    always_comb begin
        {a, b, c, d, e, f, g, h} = st_i;
        t1   = h + big_sigma1(e) + ch(e, f, g) + k_i + w_i;
        t2   = big_sigma0(a) + maj(a, b, c);
        st_o = {t1 + t2, a, b, c, d + t1, e, f, g};
    end

endmodule

// File: rtl/sha256_core_iter.sv
// sha256_core_iter: iterative SHA-256 / SHA-224 compression core.
// Takes pre-padded 512-bit blocks, chains multi-block messages through the
// internal H registers and runs ROUNDS_PER_CLK rounds per clock.
//   clk, rst        clock, synchronous active-high reset
//   blk_valid/ready block handshake; blk_data word 0 in [511:480]
//   blk_first       first block of a message: reload IV, sample mode_224
//   blk_last        last block: publish digest when done
//   mode_224        SHA-224 select (only with SUPPORT_224 != 0)
//   digest          last published digest; SHA-224 uses [255:32], [31:0]=0
//   digest_valid    one-cycle pulse when digest updates
//   busy            high in every state except IDLE
//   state_dbg       current control state
//
// Handshake: a block transfers on a rising clk edge where blk_valid and
// blk_ready are both high. blk_ready is high exactly in IDLE, so blk_valid
// seen while busy is not taken; the producer keeps offering until it is.
module sha256_core_iter
    import sha256_pkg::*;
#(
    parameter int ROUNDS_PER_CLK = 1,
    parameter bit SUPPORT_224    = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    input  logic         blk_first,
    input  logic         blk_last,
    input  logic         mode_224,
    output logic [255:0] digest,
    output logic         digest_valid,
    output logic         busy,
    output state_t       state_dbg
);

    if (!(ROUNDS_PER_CLK == 1 || ROUNDS_PER_CLK == 2 || ROUNDS_PER_CLK == 4 ||
          ROUNDS_PER_CLK == 8 || ROUNDS_PER_CLK == 16)) begin : g_bad_rounds
        $error("sha256_core_iter: ROUNDS_PER_CLK must be 1, 2, 4, 8 or 16");
    end

    state_t       state_q, state_d;
    logic [6:0]   cnt_q;
    logic [6:0]   cnt_d;
    logic [255:0] work_q;
    logic [255:0] h_q;
    word_t        w_q [16];
    word_t        w_d [16];
    logic         chain_q;
    logic         mode_q;
    logic         last_q;
    logic [255:0] digest_q;
    logic         dvalid_q;

    logic         accept;
    logic         mode_sel;
    logic [255:0] iv_sel;
    logic [255:0] h_sum;
    logic [255:0] rounds_out;

    assign accept   = blk_valid && blk_ready;
    assign mode_sel = SUPPORT_224 && mode_224;
    assign iv_sel   = mode_sel ? IV224 : IV256;
    assign cnt_d    = cnt_q + 7'(ROUNDS_PER_CLK);

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ROUND;
            ROUND:   if (cnt_d == 7'd64) state_d = FINAL;
            FINAL:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        blk_ready = (state_q == IDLE);
        busy      = (state_q != IDLE);
        state_dbg = state_q;
    end

    // Rolling schedule window: w_q holds W[t..t+15] where t = cnt_q. The
    // window is extended to 32 words and the next window starts R words in.
    always_comb begin
        word_t ext [32];
        for (int j = 0; j < 16; j++) ext[j] = w_q[j];
        for (int j = 16; j < 32; j++) begin
            ext[j] = small_sigma1(ext[j-2]) + ext[j-7]
                   + small_sigma0(ext[j-15]) + ext[j-16];
        end
        for (int j = 0; j < 16; j++) w_d[j] = ext[j+ROUNDS_PER_CLK];
    end

    // R chained rounds; round i of this cycle is round cnt_q+i of the block.
    for (genvar i = 0; i < ROUNDS_PER_CLK; i++) begin : g_rnd
        logic [255:0] st_in;
        logic [255:0] st_out;
        if (i == 0) begin : g_head
            assign st_in = work_q;
        end else begin : g_tail
            assign st_in = g_rnd[i-1].st_out;
        end
        sha256_round u_round (
            .st_i (st_in),
            .k_i  (k_at(cnt_q[5:0] + 6'(i))),
            .w_i  (w_q[i]),
            .st_o (st_out)
        );
    end
    assign rounds_out = g_rnd[ROUNDS_PER_CLK-1].st_out;

    always_comb begin
        h_sum = '0;
        for (int i = 0; i < 8; i++) begin
            h_sum[255-32*i -: 32] = h_q[255-32*i -: 32] + work_q[255-32*i -: 32];
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            work_q   <= '0;
            h_q      <= IV256;
            chain_q  <= 1'b0;
            mode_q   <= 1'b0;
            last_q   <= 1'b0;
            digest_q <= '0;
            dvalid_q <= 1'b0;
            for (int j = 0; j < 16; j++) w_q[j] <= '0;
        end else begin
            dvalid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        for (int j = 0; j < 16; j++) w_q[j] <= blk_data[511-32*j -: 32];
                        cnt_q  <= '0;
                        last_q <= blk_last;
                        // A new first block restarts the chain (and drops any
                        // unfinished one); otherwise continue from H.
                        if (blk_first || !chain_q) begin
                            h_q    <= iv_sel;
                            work_q <= iv_sel;
                            mode_q <= mode_sel;
                        end else begin
                            work_q <= h_q;
                        end
                    end
                end
                ROUND: begin
                    work_q <= rounds_out;
                    cnt_q  <= cnt_d;
                    for (int j = 0; j < 16; j++) w_q[j] <= w_d[j];
                end
                FINAL: begin
                    h_q <= h_sum;
                    if (last_q) begin
                        digest_q <= mode_q ? {h_sum[255:32], 32'h0} : h_sum;
                        dvalid_q <= 1'b1;
                        chain_q  <= 1'b0;
                    end else begin
                        chain_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign digest       = digest_q;
    assign digest_valid = dvalid_q;

endmodule

// File: tb/tb_sha256_core_iter.sv
// Directed bench for sha256_core_iter: three instances (R=1, 4, 16) share
// block data and flags, each with its own blk_valid. Expected digests are
// the published SHA-256 / SHA-224 test vectors.
module tb_sha256_core_iter;
    import sha256_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic [511:0] blk_data  = '0;
    logic         blk_first = 1'b0;
    logic         blk_last  = 1'b0;
    logic         mode_224  = 1'b0;
    logic         v1 = 1'b0, v4 = 1'b0, v16 = 1'b0;
    logic         r1, r4, r16;
    logic [255:0] d1, d4, d16;
    logic         dv1, dv4, dv16;
    logic         b1, b4, b16;
    state_t       s1, s4, s16;

    sha256_core_iter #(.ROUNDS_PER_CLK(1), .SUPPORT_224(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .blk_valid(v1), .blk_ready(r1), .blk_data(blk_data),
        .blk_first(blk_first), .blk_last(blk_last), .mode_224(mode_224),
        .digest(d1), .digest_valid(dv1), .busy(b1), .state_dbg(s1));

    sha256_core_iter #(.ROUNDS_PER_CLK(4), .SUPPORT_224(1'b1)) u_dut4 (
        .clk(clk), .rst(rst), .blk_valid(v4), .blk_ready(r4), .blk_data(blk_data),
        .blk_first(blk_first), .blk_last(blk_last), .mode_224(mode_224),
        .digest(d4), .digest_valid(dv4), .busy(b4), .state_dbg(s4));

    sha256_core_iter #(.ROUNDS_PER_CLK(16), .SUPPORT_224(1'b1)) u_dut16 (
        .clk(clk), .rst(rst), .blk_valid(v16), .blk_ready(r16), .blk_data(blk_data),
        .blk_first(blk_first), .blk_last(blk_last), .mode_224(mode_224),
        .digest(d16), .digest_valid(dv16), .busy(b16), .state_dbg(s16));

    // ---------------- vectors ----------------
    logic [511:0] blk_abc   = {32'h61626380, 448'h0, 32'h00000018};
    logic [511:0] blk_empty = {32'h80000000, 480'h0};
    logic [511:0] blk_two1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                               32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                               32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                               32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    logic [511:0] blk_two2  = {480'h0, 32'h000001c0};

    logic [255:0] exp_abc   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    logic [255:0] exp_empty = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    logic [255:0] exp_two   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    logic [255:0] exp_224   = 256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000;

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // ---------------- per-instance access ----------------
    task automatic set_valid(input int sel, input logic val);
        case (sel)
            1:       v1  = val;
            4:       v4  = val;
            default: v16 = val;
        endcase
    endtask

    function automatic logic get_ready(input int sel);
        return (sel == 1) ? r1 : (sel == 4) ? r4 : r16;
    endfunction
    function automatic logic get_dv(input int sel);
        return (sel == 1) ? dv1 : (sel == 4) ? dv4 : dv16;
    endfunction
    function automatic logic get_busy(input int sel);
        return (sel == 1) ? b1 : (sel == 4) ? b4 : b16;
    endfunction
    function automatic state_t get_state(input int sel);
        return (sel == 1) ? s1 : (sel == 4) ? s4 : s16;
    endfunction
    function automatic logic [255:0] get_digest(input int sel);
        return (sel == 1) ? d1 : (sel == 4) ? d4 : d16;
    endfunction

    // ---------------- driver ----------------
    // Offers one block, waits for acceptance, then runs until the core is idle
    // again. lat = accept cycle to first idle cycle (the digest_valid cycle for
    // a last block). With junk set, a different block is offered while busy.
    task automatic run_block(input int sel, input logic [511:0] data,
                             input logic first, input logic last, input logic mode,
                             input logic junk, output int lat, output logic dv_seen);
        int   t_acc;
        logic got;
        blk_data  = data;
        blk_first = first;
        blk_last  = last;
        mode_224  = mode;
        set_valid(sel, 1'b1);
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (get_ready(sel)) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("accept_wait", {255'b0, got}, 256'd1);
        t_acc = cyc;
        @(posedge clk); #1;
        set_valid(sel, 1'b0);
        dv_seen = 1'b0;
        lat     = -1;
        for (int i = 0; i < 200; i++) begin
            if (get_dv(sel)) dv_seen = 1'b1;
            if (!get_busy(sel)) begin
                lat = cyc - t_acc;
                break;
            end
            if (junk) begin
                if (get_state(sel) == FINAL) begin
                    set_valid(sel, 1'b0);
                end else begin
                    blk_data  = ~data;
                    blk_first = 1'b1;
                    blk_last  = 1'b1;
                    mode_224  = 1'b1;
                    set_valid(sel, 1'b1);
                end
            end
            @(posedge clk); #1;
        end
        set_valid(sel, 1'b0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int   lat;
        logic dvs;
        logic dv_any;

        // reset
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready",  {255'b0, r4},  256'd1);
        chk("rst_busy",   {255'b0, b4},  256'd0);
        chk("rst_dvalid", {255'b0, dv4}, 256'd0);
        chk("rst_digest", d4,            256'd0);
        chk("rst_state",  {254'b0, s4},  {254'b0, IDLE});
        rst = 1'b0;
        @(posedge clk); #1;

        // "abc" on every build, with latency 64/R+2
        run_block(1, blk_abc, 1'b1, 1'b1, 1'b0, 1'b0, lat, dvs);
        chk("abc_r1_dv",     {255'b0, dvs}, 256'd1);
        chk("abc_r1_lat",    256'(lat),     256'd66);
        chk("abc_r1_digest", d1,            exp_abc);

        run_block(16, blk_abc, 1'b1, 1'b1, 1'b0, 1'b0, lat, dvs);
        chk("abc_r16_dv",     {255'b0, dvs}, 256'd1);
        chk("abc_r16_lat",    256'(lat),     256'd6);
        chk("abc_r16_digest", d16,           exp_abc);

        run_block(4, blk_abc, 1'b1, 1'b1, 1'b0, 1'b0, lat, dvs);
        chk("abc_r4_dv",     {255'b0, dvs}, 256'd1);
        chk("abc_r4_lat",    256'(lat),     256'd18);
        chk("abc_r4_digest", d4,            exp_abc);
        // ready in the same cycle as the digest pulse
        chk("b2b_ready",     {255'b0, r4 & dv4}, 256'd1);

        // empty string, accepted back-to-back
        run_block(4, blk_empty, 1'b1, 1'b1, 1'b0, 1'b0, lat, dvs);
        chk("empty_lat",    256'(lat), 256'd18);
        chk("empty_digest", d4,        exp_empty);

        // two-block message; no pulse after block 1, digest held meanwhile
        run_block(4, blk_two1, 1'b1, 1'b0, 1'b0, 1'b0, lat, dvs);
        chk("two_blk1_no_dv",  {255'b0, dvs}, 256'd0);
        chk("two_blk1_hold",   d4,            exp_empty);
        run_block(4, blk_two2, 1'b0, 1'b1, 1'b0, 1'b0, lat, dvs);
        chk("two_blk2_dv",     {255'b0, dvs}, 256'd1);
        chk("two_digest",      d4,            exp_two);

        // SHA-224 then SHA-256 (mode re-sampled on each first block)
        run_block(4, blk_abc, 1'b1, 1'b1, 1'b1, 1'b0, lat, dvs);
        chk("abc224_digest", d4, exp_224);
        run_block(4, blk_abc, 1'b1, 1'b1, 1'b0, 1'b0, lat, dvs);
        chk("abc256_after224", d4, exp_abc);

        // reset during ROUND aborts the block
        blk_data = blk_abc; blk_first = 1'b1; blk_last = 1'b1; mode_224 = 1'b0;
        v4 = 1'b1;
        @(posedge clk); #1;
        v4 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_state_round", {254'b0, s4}, {254'b0, ROUND});
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_state",  {254'b0, s4},  {254'b0, IDLE});
        chk("abort_ready",  {255'b0, r4},  256'd1);
        chk("abort_digest", d4,            256'd0);
        chk("abort_dv",     {255'b0, dv4}, 256'd0);
        rst = 1'b0;
        dv_any = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            dv_any = dv_any | dv4;
        end
        chk("abort_no_late_dv", {255'b0, dv_any}, 256'd0);
        run_block(4, blk_abc, 1'b1, 1'b1, 1'b0, 1'b0, lat, dvs);
        chk("reissue_digest", d4, exp_abc);

        // other data offered while busy is ignored
        run_block(4, blk_abc, 1'b1, 1'b1, 1'b0, 1'b1, lat, dvs);
        chk("busy_ignore_lat",    256'(lat), 256'd18);
        chk("busy_ignore_digest", d4,        exp_abc);

        // abandoned chain: first block, then a fresh single-block "abc"
        run_block(4, blk_two1, 1'b1, 1'b0, 1'b0, 1'b0, lat, dvs);
        run_block(4, blk_abc,  1'b1, 1'b1, 1'b0, 1'b0, lat, dvs);
        chk("abandon_digest", d4, exp_abc);

        // abandoned SHA-224 chain on R=16 followed by SHA-256 "abc"
        run_block(16, blk_two1, 1'b1, 1'b0, 1'b1, 1'b0, lat, dvs);
        run_block(16, blk_abc,  1'b1, 1'b1, 1'b0, 1'b0, lat, dvs);
        chk("abandon224_r16_digest", d16, exp_abc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
